// File: rtl/router_fifo_pkg.sv
// Shared router package: byte width, FIFO depth, header field positions,
// the tagged FIFO entry type and the packet-length reload helper.
package router_fifo_pkg;

  localparam int ROUTER_DATA_W     = 8;
  localparam int ROUTER_FIFO_DEPTH = 16;
  localparam int ROUTER_PKT_CNT_W  = 7;

  // Header byte layout: payload length in [7:2], destination address in [1:0].
  localparam int ROUTER_HDR_LEN_MSB  = 7;
  localparam int ROUTER_HDR_LEN_LSB  = 2;
  localparam int ROUTER_HDR_ADDR_MSB = 1;
  localparam int ROUTER_HDR_ADDR_LSB = 0;

  // One stored FIFO entry: header flag captured at write time plus the byte.
  typedef struct packed {
    logic                     hdr;
    logic [ROUTER_DATA_W-1:0] data;
  } router_fifo_entry_t;

  // Bytes still to drain after a header: payload length plus the parity byte.
  function automatic logic [ROUTER_PKT_CNT_W-1:0] pkt_len_load(
    input logic [ROUTER_DATA_W-1:0] hdr_byte
  );
    return ROUTER_PKT_CNT_W'(hdr_byte[ROUTER_HDR_LEN_MSB:ROUTER_HDR_LEN_LSB])
           + ROUTER_PKT_CNT_W'(1);
  endfunction

endpackage

// File: rtl/router_fifo_if.sv
// Handshake/data bundle between the router data register block, the
// per-port FIFO and the destination-side reader.
interface router_fifo_if
  import router_fifo_pkg::*;
#(
  parameter int WIDTH = ROUTER_DATA_W,
  parameter int DEPTH = ROUTER_FIFO_DEPTH
) ();

  localparam int ADDR_W = $clog2(DEPTH);

  logic              soft_rst;
  logic              we;
  logic              re;
  logic              lfd_state;
  logic [WIDTH-1:0]  data_in;
  logic [WIDTH-1:0]  dout;
  logic              dout_valid;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              pkt_busy;

  // Producer/reader side: drives requests, observes data and status.
  modport master (
    output soft_rst, we, re, lfd_state, data_in,
    input  dout, dout_valid, full, empty, count, pkt_busy
  );

  // FIFO side.
  modport slave (
    input  soft_rst, we, re, lfd_state, data_in,
    output dout, dout_valid, full, empty, count, pkt_busy
  );

endinterface

// File: rtl/router_fifo_mem.sv
// Simple dual-port register array: one synchronous write port and one
// asynchronous (combinational) read port.
module router_fifo_mem #(
  parameter int ENTRY_W = 9,
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  // Store the tagged entry at the write pointer.
  // NOTE: the array is deliberately left out of reset; the pointers alone
  // define which entries are valid, and a reset here would force flops
  // instead of a plain register file.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/router_fifo.sv
// Per-output-port packet buffer of the 1x3 router. Stores header-tagged
// bytes, returns them in order with a registered read, and tracks the
// remaining length of the packet being read out.
// Optional feature: define ROUTER_FIFO_SOFT_RST_EN to make soft_rst a
// synchronous flush; otherwise soft_rst is ignored.
module router_fifo
  import router_fifo_pkg::*;
#(
  parameter int WIDTH  = ROUTER_DATA_W,
  parameter int DEPTH  = ROUTER_FIFO_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input logic          clk,
  input logic          rst,
  router_fifo_if.slave bus
);

  logic [ADDR_W:0]               wptr;
  logic [ADDR_W:0]               rptr;
  logic [ROUTER_PKT_CNT_W-1:0]   pkt_cnt;
  logic [WIDTH-1:0]              dout_q;
  logic                          dout_valid_q;
  logic [WIDTH:0]                wr_entry;
  logic [WIDTH:0]                rd_entry;
  logic                          full;
  logic                          empty;
  logic                          wr_ok;
  logic                          rd_ok;
  logic                          flush;

`ifdef ROUTER_FIFO_SOFT_RST_EN
  assign flush = bus.soft_rst;
`else
  logic unused_soft_rst;
  assign unused_soft_rst = bus.soft_rst;
  assign flush           = 1'b0;
`endif

  // Flags are decoded from the start-of-cycle pointers, so a read at full
  // frees no room for a same-cycle write and an empty FIFO has no bypass.
  assign empty = (wptr == rptr);
  assign full  = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                 (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
  assign wr_ok = bus.we && !full;
  assign rd_ok = bus.re && !empty;

  assign wr_entry = {bus.lfd_state, bus.data_in};

  router_fifo_mem #(
    .ENTRY_W (WIDTH + 1),
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_ok && !flush),
    .waddr (wptr[ADDR_W-1:0]),
    .wdata (wr_entry),
    .raddr (rptr[ADDR_W-1:0]),
    .rdata (rd_entry)
  );

  // Advance pointers on accepted transfers; flush returns them to zero.
  // NOTE: all state updates use non-blocking assignments so every flop
  // samples start-of-cycle values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
    end
  end

  // Registered read data and its one-cycle valid strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else if (flush) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      dout_valid_q <= rd_ok;
      if (rd_ok) dout_q <= rd_entry[WIDTH-1:0];
    end
  end

  // Remaining bytes of the packet being read: reload on every header,
  // count down on body bytes until zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt <= '0;
    end else if (flush) begin
      pkt_cnt <= '0;
    end else if (rd_ok) begin
      if (rd_entry[WIDTH]) begin
        pkt_cnt <= pkt_len_load(rd_entry[ROUTER_DATA_W-1:0]);
      end else if (pkt_cnt != '0) begin
        pkt_cnt <= pkt_cnt - 1'b1;
      end
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.full       = full;
  assign bus.empty      = empty;
  assign bus.count      = wptr - rptr;
  assign bus.pkt_busy   = (pkt_cnt != '0);

endmodule

// File: tb/tb_router_fifo.sv
// Self-checking bench for router_fifo: a queue-based model of the FIFO and
// packet counter, a per-cycle compare process, and directed hand checks.
// Expectations follow ROUTER_FIFO_SOFT_RST_EN when it is defined.
module tb_router_fifo
  import router_fifo_pkg::*;
();

  localparam int DEPTH = ROUTER_FIFO_DEPTH;

  logic clk = 1'b0;
  logic rst = 1'b1;

  router_fifo_if bus ();

  router_fifo dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Reference model state.
  router_fifo_entry_t mq[$];
  logic [7:0]         m_dout;
  bit                 m_valid;
  int                 m_pkt;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_dout  = 8'h00;
    m_valid = 1'b0;
    m_pkt   = 0;
  endtask

  // Apply one clock edge's worth of FIFO rules to the model.
  task automatic model_edge(input logic we, input logic re, input logic lfd,
                            input logic [7:0] d, input logic srst);
    bit was_full, was_empty;
    router_fifo_entry_t e;
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
`ifdef ROUTER_FIFO_SOFT_RST_EN
    if (srst) begin
      model_reset();
      return;
    end
`endif
    if (re && !was_empty) begin
      e       = mq.pop_front();
      m_dout  = e.data;
      m_valid = 1'b1;
      if (e.hdr)           m_pkt = int'(e.data >> 2) + 1;
      else if (m_pkt != 0) m_pkt = m_pkt - 1;
    end else begin
      m_valid = 1'b0;
    end
    if (we && !was_full) mq.push_back('{hdr: lfd, data: d});
  endtask

  // Drive one cycle from the falling edge, update the model on the rising
  // edge, and return at the next falling edge with outputs settled.
  task automatic step(input logic we, input logic re, input logic lfd,
                      input logic [7:0] d, input logic srst = 1'b0);
    bus.we        = we;
    bus.re        = re;
    bus.lfd_state = lfd;
    bus.data_in   = d;
    bus.soft_rst  = srst;
    @(posedge clk);
    model_edge(we, re, lfd, d, srst);
    @(negedge clk);
    bus.we       = 1'b0;
    bus.re       = 1'b0;
    bus.soft_rst = 1'b0;
  endtask

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("count",      32'(bus.count),      32'(mq.size()));
      check("full",       32'(bus.full),       32'(mq.size() == DEPTH));
      check("empty",      32'(bus.empty),      32'(mq.size() == 0));
      check("pkt_busy",   32'(bus.pkt_busy),   32'(m_pkt != 0));
      check("dout_valid", 32'(bus.dout_valid), 32'(m_valid));
      check("dout",       32'(bus.dout),       32'(m_dout));
    end
  end

  logic [7:0] exp_drain [5] = '{8'h0D, 8'hA1, 8'hA2, 8'hA3, 8'h0F};
  int         exp_pkt   [5] = '{4, 3, 2, 1, 0};
  logic       w_en;
  logic       r_en;
  int         wi;
  int         nrd;

  initial begin
    bus.we = 1'b0; bus.re = 1'b0; bus.lfd_state = 1'b0;
    bus.data_in = 8'h00; bus.soft_rst = 1'b0;
    model_reset();

    // Reset held for two cycles.
    repeat (2) @(negedge clk);
    check("rst_empty",    32'(bus.empty),    32'd1);
    check("rst_full",     32'(bus.full),     32'd0);
    check("rst_count",    32'(bus.count),    32'd0);
    check("rst_dout",     32'(bus.dout),     32'h00);
    check("rst_pkt_busy", 32'(bus.pkt_busy), 32'd0);
    rst    = 1'b0;
    chk_en = 1'b1;

    // Packet drain: header 0x0D (length 3), three payload bytes, parity.
    step(1, 0, 1, 8'h0D);
    check("first_wr_empty", 32'(bus.empty), 32'd0);
    step(1, 0, 0, 8'hA1);
    step(1, 0, 0, 8'hA2);
    step(1, 0, 0, 8'hA3);
    step(1, 0, 0, 8'h0F);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 8'h00);
      check("drain_dout",    32'(bus.dout),       32'(exp_drain[i]));
      check("drain_pkt_cnt", 32'(dut.pkt_cnt),    32'(exp_pkt[i]));
      check("drain_valid",   32'(bus.dout_valid), 32'd1);
    end
    check("drain_pkt_busy", 32'(bus.pkt_busy), 32'd0);

    // Fill to full, drop a 17th write, then read everything back.
    for (int i = 0; i < 16; i++) step(1, 0, 0, 8'(i));
    check("fill_full",  32'(bus.full),  32'd1);
    check("fill_count", 32'(bus.count), 32'd16);
    step(1, 0, 0, 8'hFF);
    check("drop_count", 32'(bus.count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 0, 8'h00);
      check("fill_rd", 32'(bus.dout), 32'(i));
    end
    check("fill_empty", 32'(bus.empty), 32'd1);

    // Simultaneous read/write at full: read wins, written byte is lost.
    for (int i = 0; i < 16; i++) step(1, 0, 0, 8'(8'h20 + i));
    step(1, 1, 0, 8'hFF);
    check("rw_full_count", 32'(bus.count), 32'd15);
    check("rw_full_full",  32'(bus.full),  32'd0);
    check("rw_full_dout",  32'(bus.dout),  32'h20);
    for (int i = 1; i < 16; i++) begin
      step(0, 1, 0, 8'h00);
      check("rw_full_rd", 32'(bus.dout), 32'(8'h20 + i));
    end
    check("rw_full_drained", 32'(bus.empty), 32'd1);

    // Simultaneous read/write at empty: write wins, no bypass.
    step(1, 1, 0, 8'h55);
    check("rw_empty_count", 32'(bus.count),      32'd1);
    check("rw_empty_valid", 32'(bus.dout_valid), 32'd0);
    step(0, 1, 0, 8'h00);
    check("rw_empty_rd", 32'(bus.dout), 32'h55);

    // Wrap-around stream: 40 bytes, occupancy capped at 10.
    wi  = 0;
    nrd = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (wi == 40 && mq.size() == 0) break;
      w_en = (wi < 40) && (mq.size() < 10);
      r_en = (cyc % 3) != 0;
      step(w_en, r_en, 0, 8'(8'h40 + wi));
      if (w_en) wi++;
      if (bus.dout_valid) nrd++;
    end
    check("wrap_reads", 32'(nrd), 32'd40);
    check("wrap_last",  32'(bus.dout), 32'h67);

    // Flush mid-packet: header 0x0C (length 3) plus 7 body bytes, two read.
    step(1, 0, 1, 8'h0C);
    for (int i = 1; i < 8; i++) step(1, 0, 0, 8'(8'hB0 + i));
    step(0, 1, 0, 8'h00);
    step(0, 1, 0, 8'h00);
    check("pre_flush_pkt",   32'(dut.pkt_cnt), 32'd3);
    check("pre_flush_count", 32'(bus.count),   32'd6);
    step(1, 0, 0, 8'hEE, 1'b1);
`ifdef ROUTER_FIFO_SOFT_RST_EN
    check("flush_empty",    32'(bus.empty),    32'd1);
    check("flush_count",    32'(bus.count),    32'd0);
    check("flush_pkt_busy", 32'(bus.pkt_busy), 32'd0);
    check("flush_dout",     32'(bus.dout),     32'h00);
`else
    check("noflush_count",    32'(bus.count),    32'd7);
    check("noflush_pkt_busy", 32'(bus.pkt_busy), 32'd1);
    check("noflush_dout",     32'(bus.dout),     32'hB1);
    repeat (7) step(0, 1, 0, 8'h00);
    check("noflush_drained", 32'(bus.empty), 32'd1);
`endif

    // Asynchronous reset between clock edges while holding data.
    step(1, 0, 1, 8'h10);
    step(1, 0, 0, 8'h11);
    step(0, 1, 0, 8'h00);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("arst_empty", 32'(bus.empty),    32'd1);
    check("arst_count", 32'(bus.count),    32'd0);
    check("arst_dout",  32'(bus.dout),     32'h00);
    check("arst_busy",  32'(bus.pkt_busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step(0, 0, 0, 8'h00);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/router_fifo.md
# router_fifo

Per-output-port packet buffer of the 1x3 router. Sits directly downstream of the router's data register block: it stores each byte that block drives onto its `dout` bus, tagged with whether it is a packet header. It returns the bytes in order to the destination-side reader. It also tracks the remaining length of the packet currently being read, so the output side knows when a packet has fully drained.

## Interface
- `WIDTH`, 8, data byte width
- `DEPTH`, 16, number of entries (power of two, ≥ 2)
- `ADDR_W`, $clog2(DEPTH), pointer index width

Ports:
- `clk`  input  1  single clock; all logic on rising edge
- `rst`  input  1  reset, asynchronous, active-high
- `soft_rst`  input  1  synchronous flush request (see Configuration)
- `we`  input  1  write enable
- `re`  input  1  read enable
- `lfd_state`  input  1  high when the byte being written is a header
- `data_in`  input  WIDTH  byte from the register block's `dout`
- `dout`  output  WIDTH  registered read data
- `dout_valid`  output  1  high for one cycle after each accepted read
- `full`  output  1  all DEPTH entries occupied
- `empty`  output  1  no entries occupied
- `count`  output  ADDR_W+1  current fill level, 0..DEPTH
- `pkt_busy`  output  1  a read packet is still draining (`pkt_cnt` ≠ 0)

## Operation
- Storage: DEPTH entries of WIDTH+1 bits. Bit WIDTH holds the header flag (the `lfd_state` value at write time). Bits WIDTH-1:0 hold `data_in`.
- Pointers `wptr` and `rptr` are ADDR_W+1 bits and wrap naturally.
  - `empty` = pointers equal.
  - `full` = MSBs differ and low ADDR_W bits equal.
  - `count` = `wptr` − `rptr` (modulo 2^(ADDR_W+1)).
- Write accepted when `we` && !`full`: store the entry, then increment `wptr`. A write while `full` is dropped and leaves the FIFO unchanged.
- Read accepted when `re` && !`empty`:
  - `dout` ← entry data.
  - `dout_valid` ← 1.
  - `rptr` increments.
  - A read while `empty` is ignored, `dout` holds its value and `dout_valid` ← 0.
- `full` and `empty` are evaluated from start-of-cycle state:
  - Simultaneous read and write while full: the read is accepted and the write is dropped.
  - Simultaneous read and write while empty: the write is accepted and the read is ignored. There is no bypass path.
  - Otherwise both are accepted and `count` is unchanged.
- Packet counter `pkt_cnt` (7 bits):
  - On an accepted read of a header entry: `pkt_cnt` ← data[7:2] + 1 (payload length plus parity byte).
  - On an accepted read of a non-header entry with `pkt_cnt` ≠ 0: decrement.
  - A header read always reloads the counter, even if it is non-zero. That case is a truncated previous packet and is not flagged.
- `dout` holds its last read value until the next accepted read, `rst`, or flush.
- Reset values: `dout` 0, `dout_valid` 0, `full` 0, `empty` 1, `count` 0, `pkt_busy` 0. Pointers and `pkt_cnt` reset to 0. Memory contents are not reset.

## Timing
- Write-to-flag latency is 1 cycle: `empty` deasserts the cycle after the first accepted write.
- Read latency is 1 cycle: `dout` and `dout_valid` are updated on the edge that samples `re`.
- `full`, `empty`, `count` and `pkt_busy` are combinational decodes of registered state and are glitch-free relative to `clk`.
- `rst` asserted mid-packet clears everything immediately, asynchronously. There is no recovery of in-flight data.
- Flush (when enabled) has priority over `we` and `re` in the same cycle. The state after the flush edge equals the reset state.

## Configuration
- `ROUTER_FIFO_SOFT_RST_EN`
  - Defined: `soft_rst` high on a rising edge clears both pointers, `pkt_cnt`, `dout` and `dout_valid` to their reset values. It overrides a concurrent read or write. This is used by the router's read-timeout logic to discard an unread packet.
  - Undefined: the `soft_rst` port remains present but is ignored. No flush logic is synthesized.

## Structure
- Shared router package holds:
  - `ROUTER_DATA_W` = 8
  - `ROUTER_FIFO_DEPTH` = 16
  - the header field slice constants: length [7:2], address [1:0]
  - a typedef for the tagged FIFO entry, `{logic hdr; logic [7:0] data;}`
- One natural sub-module: `router_fifo_mem`, a simple dual-port register array with a write port and an asynchronous read port. Pointer, flag and counter logic stay in `router_fifo`.

## Test plan
- Reset: assert `rst` for 2 cycles → `empty`=1, `full`=0, `count`=0, `dout`=8'h00, `pkt_busy`=0.
- Packet drain:
  - Stimulus: write header 8'h0D with `lfd_state`=1 (length 3), then payload 8'hA1, 8'hA2, 8'hA3 and parity 8'h0F; read 5 times.
  - Required: `dout` sequence 0D, A1, A2, A3, 0F; `pkt_cnt` 4→3→2→1→0; `pkt_busy` low after the 5th read.
- Fill: 16 writes (8'h00..8'h0F) → `full`=1, `count`=16. A 17th write of 8'hFF is dropped; 16 reads return 00..0F and `empty`=1.
- Simultaneous at boundaries:
  - At full, `we`+`re` for one cycle → `count`=15, `full`=0, and the written byte is absent.
  - At empty, `we`+`re` → `count`=1, `dout_valid`=0.
- Wrap-around: stream 40 bytes with interleaved reads, never exceeding 10 entries → output order identical to input, with no spurious flag toggles.
- Flush, with `ROUTER_FIFO_SOFT_RST_EN`:
  - Stimulus: 6 entries stored mid-packet (`pkt_cnt`=3), then pulse `soft_rst` together with `we`.
  - Required: next cycle `empty`=1, `count`=0, `pkt_busy`=0, `dout`=0.
  - Without the macro, the same stimulus leaves `count`=7.
